cpu_run_ctrl: RTL and testbench
===============================

# cpu_run_ctrl

Synthesizable run controller for the pipelined MIPS core, standing between board-level clock/reset and the core's `clk`/`reset` ports. It converts an asynchronous active-low board reset into the core's synchronous active-high reset with a guaranteed hold length, then supervises execution. Execution ends in DONE when the core parks in a self-loop or when a cycle budget expires. It takes over on hardware the stimulus role the simulation bench plays for the core.

## Interface
Parameters:
- `RST_CYCLES`, 4: cycles `cpu_reset` stays high after the synchronized reset release.
- `HALT_CYCLES`, 8: consecutive cycles with unchanged PC that count as a halt.
- `TIMEOUT`, 5000: run-cycle budget before forced DONE.
- `CNT_W`, 32: width of `cycle_count`.

Ports:
- `clk`, in, 1: single clock for the block and the core.
- `reset`, in, 1: asynchronous, active-low.
- `pc`, in, 32: core's fetch-stage PC.
- `soft_req`, in, 1: software/debug re-run request, level, four-phase.
- `soft_ack`, out, 1: acknowledge for `soft_req`.
- `cpu_reset`, out, 1: synchronous active-high reset to the core.
- `running`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `done_reason`, out, 2: 00 none, 01 halt, 10 timeout.
- `cycle_count`, out, CNT_W: RUN cycles since the last reset.

## Operation
- **Reset (`reset`=0):** all flops clear immediately.
  - state=HOLD, `cpu_reset`=1, `running`=0, `done`=0, `done_reason`=00.
  - `cycle_count`=0, `soft_ack`=0; synchronizer flops, hold counter, stable counter and `pc_q` all 0.
- **HOLD**
  - The hold counter runs only while the synchronized release `rst_ok`=1. It increments each cycle.
  - At count RST_CYCLES-1, go to RUN. `cpu_reset`=0 from that edge.
- **RUN**
  - `cycle_count` increments each cycle and saturates at all-ones.
  - `pc_q`<=`pc`. If `pc`==`pc_q`, the stable counter increments; otherwise it clears.
  - The first RUN cycle loads `pc_q` only, with stable=0.
  - Stable reaching HALT_CYCLES: go to DONE with reason 01.
  - `cycle_count` reaching TIMEOUT-1 as it increments: go to DONE with reason 10.
  - Halt and timeout in the same cycle: halt wins, reason 01.
- **DONE**
  - `cpu_reset`=0 (the core keeps running). `cycle_count` and `done_reason` are frozen.
- **Soft re-run**
  - In RUN or DONE, `soft_req`=1 with `soft_ack`=0: go to HOLD, clear all counters and `done_reason`, set `soft_ack`=1.
  - `soft_ack` drops the cycle after `soft_req` is sampled 0.
  - A new request is accepted only once `soft_ack`=0 and state is RUN or DONE.
  - `soft_req` in HOLD with `soft_ack`=0 is ignored.
- **Mid-operation async reset:** overrides everything and forces the reset values above, including dropping `soft_ack`.

## Timing
- Release path: `reset` rises, then 2 clk edges to `rst_ok`=1, then RST_CYCLES edges in HOLD.
  - `cpu_reset` therefore falls on edge 2+RST_CYCLES after the release, which is 6 with defaults.
- All outputs are registered. No combinational path from inputs to outputs.
- `done` rises on the edge where the stable counter would reach HALT_CYCLES. This is HALT_CYCLES+1 edges after the PC first repeats its value.
- `soft_ack` rises on the edge that enters HOLD. `cpu_reset` is high that same edge. The synchronizer is not re-cleared, so the hold lasts exactly RST_CYCLES.
- Counter widths:
  - hold counter: $clog2(RST_CYCLES+1)
  - stable counter: $clog2(HALT_CYCLES+1)
  - timeout comparison: against `cycle_count` zero-extended to 32 bits.

## Structure
- Package `cpu_run_pkg` holds:
  - state encoding HOLD=2'd0, RUN=2'd1, DONE=2'd2;
  - reason codes REASON_NONE=2'b00, REASON_HALT=2'b01, REASON_TIMEOUT=2'b10.
- Sub-module `rst_sync`: a 2-flop synchronizer with asynchronous clear and synchronous release, producing `rst_ok`.
- The top contains the FSM, the three counters and the `pc_q` register.

## Test plan
- **Power-on:** `reset`=0 for 3 cycles, then 1.
  - `cpu_reset`=1 through edge 5 after release and 0 from edge 6.
  - `running` rises on edge 6.
- **Halt:** PC steps 0x3000, 0x3004, … then sticks at 0x3010.
  - `done`=1 and `done_reason`=01 on the 9th edge after 0x3010 first repeats.
  - `cycle_count` is frozen thereafter.
- **Timeout:** PC always changes, TIMEOUT=20.
  - `done`=1 with `done_reason`=10 and `cycle_count`=20.
- **Simultaneous:** TIMEOUT and HALT_CYCLES thresholds hit on the same edge.
  - `done_reason`=01.
- **Soft re-run:** from DONE, `soft_req`=1.
  - Next edge: `soft_ack`=1, `cpu_reset`=1, `cycle_count`=0.
  - `cpu_reset` falls 4 edges later.
  - `soft_ack` clears one edge after `soft_req`=0.
  - A second `soft_req` pulse while `soft_ack`=1 is ignored.
- **Mid-run reset:** `reset`=0 asynchronously while `cycle_count`=100.
  - All outputs take their reset values before the next edge, including `soft_ack`=0.

Source files
------------

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: state encoding and done-reason codes shared by the run controller
package cpu_run_pkg;
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [1:0] REASON_NONE    = 2'b00;
    localparam logic [1:0] REASON_HALT    = 2'b01;
    localparam logic [1:0] REASON_TIMEOUT = 2'b10;
endpackage

// File: rtl/rst_sync.sv
// rst_sync: 2-flop reset synchronizer, asynchronous clear, synchronous release
//   clk    - clock
//   reset  - asynchronous active-low reset
//   rst_ok - high two edges after reset is released
module rst_sync (
    input  logic clk,
    input  logic reset,
    output logic rst_ok
);
    logic [1:0] r_sync;
    always_ff @(posedge clk or negedge reset)
        if (!reset) r_sync <= 2'b00;
        else        r_sync <= {r_sync[0], 1'b1};
    assign rst_ok = r_sync[1];
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds the core in reset after board reset, then supervises the run until halt or timeout
//   clk         - clock shared with the core
//   reset       - asynchronous active-low board reset
//   pc          - core fetch-stage PC
//   soft_req    - re-run request (level, four-phase), soft_ack its acknowledge
//   cpu_reset   - synchronous active-high reset to the core
//   running     - high in RUN, done high in DONE, done_reason why DONE was entered
//   cycle_count - saturating count of RUN cycles since the last (soft) reset
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int RST_CYCLES  = 4,
    parameter int HALT_CYCLES = 8,
    parameter int TIMEOUT     = 5000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc,
    input  logic             soft_req,
    output logic             soft_ack,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic [1:0]       done_reason,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int HW = $clog2(RST_CYCLES + 1);
    localparam int SW = $clog2(HALT_CYCLES + 1);

    state_t           r_state, w_state_n;
    logic [HW-1:0]    r_hold, w_hold_n;
    logic [SW-1:0]    r_stable, w_stable_n;
    logic [31:0]      r_pc_q, w_pc_q_n;
    logic [CNT_W-1:0] r_cycle, w_cycle_n;
    logic [1:0]       r_reason, w_reason_n;
    logic             r_ack, w_ack_n;
    logic             r_first, w_first_n;
    logic             w_rst_ok, w_same, w_halt, w_tmo, w_accept;

    rst_sync u_sync (.clk(clk), .reset(reset), .rst_ok(w_rst_ok));

    // The first RUN cycle only primes pc_q, so a stale pc_q can never count as a repeat.
    assign w_same   = pc == r_pc_q;
    assign w_halt   = !r_first && w_same && (r_stable == SW'(HALT_CYCLES - 1));
    assign w_tmo    = 32'(r_cycle) == 32'(TIMEOUT - 1);
    assign w_accept = soft_req && !r_ack && (r_state != HOLD);

    always_comb begin
        w_state_n  = r_state;
        w_hold_n   = r_hold;
        w_stable_n = r_stable;
        w_pc_q_n   = r_pc_q;
        w_cycle_n  = r_cycle;
        w_reason_n = r_reason;
        w_first_n  = r_first;
        w_ack_n    = r_ack && soft_req;
        if (w_accept) begin
            // Synchronizer stays released, so the re-run hold is exactly RST_CYCLES.
            w_state_n  = HOLD;
            w_hold_n   = '0;
            w_stable_n = '0;
            w_cycle_n  = '0;
            w_reason_n = REASON_NONE;
            w_ack_n    = 1'b1;
        end else if (r_state == HOLD) begin
            if (w_rst_ok) begin
                w_hold_n  = (r_hold == HW'(RST_CYCLES - 1)) ? '0 : r_hold + 1'b1;
                w_state_n = (r_hold == HW'(RST_CYCLES - 1)) ? RUN : HOLD;
                w_first_n = 1'b1;
            end
        end else if (r_state == RUN) begin
            w_first_n  = 1'b0;
            w_pc_q_n   = pc;
            w_cycle_n  = &r_cycle ? r_cycle : r_cycle + 1'b1;
            w_stable_n = (!r_first && w_same) ? r_stable + 1'b1 : '0;
            w_state_n  = (w_halt || w_tmo) ? DONE : RUN;
            w_reason_n = w_halt ? REASON_HALT : w_tmo ? REASON_TIMEOUT : r_reason;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= HOLD;
            r_hold   <= '0;
            r_stable <= '0;
            r_pc_q   <= '0;
            r_cycle  <= '0;
            r_reason <= REASON_NONE;
            r_ack    <= 1'b0;
            r_first  <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_hold   <= w_hold_n;
            r_stable <= w_stable_n;
            r_pc_q   <= w_pc_q_n;
            r_cycle  <= w_cycle_n;
            r_reason <= w_reason_n;
            r_ack    <= w_ack_n;
            r_first  <= w_first_n;
        end
    end

    assign soft_ack    = r_ack;
    assign cpu_reset   = r_state == HOLD;
    assign running     = r_state == RUN;
    assign done        = r_state == DONE;
    assign done_reason = r_reason;
    assign cycle_count = r_cycle;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed vectors plus hand sequences for re-run, timeout, simultaneous and mid-run reset
module tb_cpu_run_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = 32'h3000;
    logic        soft_req = 1'b0;
    logic        sreq_d = 1'b0;
    logic        soft_ack, cpu_reset, running, done;
    logic [1:0]  done_reason;
    logic [31:0] cycle_count;
    logic        soft_ack_d, cpu_reset_d, running_d, done_d;
    logic [1:0]  done_reason_d;
    logic [31:0] cycle_count_d;
    int total = 0;
    int bad = 0;

    cpu_run_ctrl #(.TIMEOUT(20)) dut (
        .clk(clk), .reset(reset), .pc(pc), .soft_req(soft_req), .soft_ack(soft_ack),
        .cpu_reset(cpu_reset), .running(running), .done(done),
        .done_reason(done_reason), .cycle_count(cycle_count)
    );

    cpu_run_ctrl dut_d (
        .clk(clk), .reset(reset), .pc(pc), .soft_req(sreq_d), .soft_ack(soft_ack_d),
        .cpu_reset(cpu_reset_d), .running(running_d), .done(done_d),
        .done_reason(done_reason_d), .cycle_count(cycle_count_d)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        cr;
        logic        run;
        logic        dn;
        logic [1:0]  rsn;
        logic [31:0] cnt;
    } vec_t;
    vec_t tv[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e;
        for (int i = 0; i < 3; i++) tv[i] = '{1'b0, 32'h3000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0};
        for (int i = 3; i < 8; i++) tv[i] = '{1'b1, 32'h3000, 1'b1, 1'b0, 1'b0, 2'd0, 32'd0};
        tv[8]  = '{1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0};
        tv[9]  = '{1'b1, 32'h3000, 1'b0, 1'b1, 1'b0, 2'd0, 32'd1};
        tv[10] = '{1'b1, 32'h3004, 1'b0, 1'b1, 1'b0, 2'd0, 32'd2};
        tv[11] = '{1'b1, 32'h3008, 1'b0, 1'b1, 1'b0, 2'd0, 32'd3};
        tv[12] = '{1'b1, 32'h300c, 1'b0, 1'b1, 1'b0, 2'd0, 32'd4};
        for (int i = 13; i < 21; i++) tv[i] = '{1'b1, 32'h3010, 1'b0, 1'b1, 1'b0, 2'd0, 32'(i - 8)};
        for (int i = 21; i < 24; i++) tv[i] = '{1'b1, 32'h3010, 1'b0, 1'b0, 1'b1, 2'd1, 32'd13};

        #1;
        chk("async_reset_state", {28'd0, soft_ack, cpu_reset, running, done}, 32'b0100);
        for (int i = 0; i < 24; i++) begin
            reset = tv[i].rst;
            pc = tv[i].pc;
            tick();
            chk($sformatf("vec%0d_flags", i), {27'd0, soft_ack, cpu_reset, running, done, done_reason},
                {27'd0, 1'b0, tv[i].cr, tv[i].run, tv[i].dn, tv[i].rsn});
            chk($sformatf("vec%0d_count", i), cycle_count, tv[i].cnt);
        end

        soft_req = 1'b1;
        tick();
        pc = pc + 4;
        chk("rerun_ack", {31'd0, soft_ack}, 32'd1);
        chk("rerun_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rerun_count", cycle_count, 32'd0);
        chk("rerun_reason", {30'd0, done_reason}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            pc = pc + 4;
            chk($sformatf("rerun_hold%0d", k), {30'd0, soft_ack, cpu_reset}, 32'b11);
        end
        tick();
        pc = pc + 4;
        chk("rerun_release", {29'd0, cpu_reset, running, soft_ack}, 32'b011);
        tick();
        pc = pc + 4;
        chk("rerun_req_held_ignored", {29'd0, cpu_reset, running, soft_ack}, 32'b011);
        chk("rerun_count1", cycle_count, 32'd1);
        soft_req = 1'b0;
        tick();
        pc = pc + 4;
        chk("ack_drop", {31'd0, soft_ack}, 32'd0);
        chk("ack_drop_count", cycle_count, 32'd2);
        e = 6;
        do begin
            tick();
            pc = pc + 4;
            e++;
        end while (!done && e < 60);
        chk("timeout_edge", e, 32'd24);
        chk("timeout_reason", {30'd0, done_reason}, 32'd2);
        chk("timeout_count", cycle_count, 32'd20);
        tick();
        chk("timeout_frozen", cycle_count, 32'd20);

        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        pc = pc + 4;
        chk("sim_ack", {31'd0, soft_ack}, 32'd1);
        e = 0;
        do begin
            tick();
            e++;
            if (e <= 15) pc = pc + 4;
            if (e == 1) chk("sim_ack_drop", {31'd0, soft_ack}, 32'd0);
        end while (!done && e < 60);
        chk("sim_edge", e, 32'd24);
        chk("sim_reason_halt_wins", {30'd0, done_reason}, 32'd1);
        chk("sim_count", cycle_count, 32'd20);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        e = 0;
        do begin
            tick();
            pc = pc + 4;
            e++;
        end while (cycle_count_d != 32'd98 && e < 200);
        soft_req = 1'b1;
        tick();
        pc = pc + 4;
        tick();
        chk("midrun_count", cycle_count_d, 32'd100);
        chk("midrun_ack_before", {31'd0, soft_ack}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrun_flags", {27'd0, soft_ack_d, cpu_reset_d, running_d, done_d, done_reason_d}, 32'b0100_00);
        chk("midrun_count_cleared", cycle_count_d, 32'd0);
        chk("midrun_ack_cleared", {30'd0, soft_ack, cpu_reset}, 32'b01);
        soft_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
